// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, opcode/funct constants and issue-entry types
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SLL  = 4'd3;
   localparam logic [3:0] ALU_SRL  = 4'd4;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_ADDU = 4'd8;
   localparam logic [3:0] ALU_SUBU = 4'd9;
   localparam logic [3:0] ALU_XOR  = 4'd10;
   localparam logic [3:0] ALU_SLTU = 4'd11;
   localparam logic [3:0] ALU_NOR  = 4'd12;
   localparam logic [3:0] ALU_SRA  = 4'd13;
   localparam logic [3:0] ALU_LUI  = 4'd14;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // Where the two operands come from for a decoded instruction
   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_REGREG,
      SRC_SHIFT,
      SRC_SEXT,
      SRC_ZEXT,
      SRC_LUI
   } opndSrc_t;

   typedef struct packed {
      logic [31:0] busA;
      logic [31:0] busB;
      logic [3:0]  aluCtrl;
      logic        illegalOp;
   } issueEntry_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational instruction decode into an ALU operand/control tuple
module alu_decode
   import alu_ctrl_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm16,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output issueEntry_t entry
);

   logic [3:0] ctrl;
   opndSrc_t   src;

   always_comb begin
      ctrl = ALU_ADD;
      src  = SRC_NONE;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  begin ctrl = ALU_ADD;  src = SRC_REGREG; end
               FN_ADDU: begin ctrl = ALU_ADDU; src = SRC_REGREG; end
               FN_SUB:  begin ctrl = ALU_SUB;  src = SRC_REGREG; end
               FN_SUBU: begin ctrl = ALU_SUBU; src = SRC_REGREG; end
               FN_AND:  begin ctrl = ALU_AND;  src = SRC_REGREG; end
               FN_OR:   begin ctrl = ALU_OR;   src = SRC_REGREG; end
               FN_XOR:  begin ctrl = ALU_XOR;  src = SRC_REGREG; end
               FN_NOR:  begin ctrl = ALU_NOR;  src = SRC_REGREG; end
               FN_SLT:  begin ctrl = ALU_SLT;  src = SRC_REGREG; end
               FN_SLTU: begin ctrl = ALU_SLTU; src = SRC_REGREG; end
               FN_SLL:  begin ctrl = ALU_SLL;  src = SRC_SHIFT;  end
               FN_SRL:  begin ctrl = ALU_SRL;  src = SRC_SHIFT;  end
               FN_SRA:  begin ctrl = ALU_SRA;  src = SRC_SHIFT;  end
               default: begin ctrl = ALU_ADD;  src = SRC_NONE;   end
            endcase
         end
         OP_ADDI:  begin ctrl = ALU_ADD;  src = SRC_SEXT; end
         OP_ADDIU: begin ctrl = ALU_ADDU; src = SRC_SEXT; end
         OP_SLTI:  begin ctrl = ALU_SLT;  src = SRC_SEXT; end
         OP_SLTIU: begin ctrl = ALU_SLTU; src = SRC_SEXT; end
         OP_ANDI:  begin ctrl = ALU_AND;  src = SRC_ZEXT; end
         OP_ORI:   begin ctrl = ALU_OR;   src = SRC_ZEXT; end
         OP_XORI:  begin ctrl = ALU_XOR;  src = SRC_ZEXT; end
         OP_LUI:   begin ctrl = ALU_LUI;  src = SRC_LUI;  end
         default:  begin ctrl = ALU_ADD;  src = SRC_NONE; end
      endcase
   end

   // LUI leaves the 16-bit shift to the ALU, so only the raw immediate travels
   always_comb begin
      entry = '{busA: 32'd0, busB: 32'd0, aluCtrl: ctrl, illegalOp: 1'b0};
      case (src)
         SRC_REGREG: begin entry.busA = rsData; entry.busB = rtData;                  end
         SRC_SHIFT:  begin entry.busA = rtData; entry.busB = {27'd0, shamt};          end
         SRC_SEXT:   begin entry.busA = rsData; entry.busB = {{16{imm16[15]}}, imm16}; end
         SRC_ZEXT:   begin entry.busA = rsData; entry.busB = {16'd0, imm16};          end
         SRC_LUI:    begin entry.busA = 32'd0;  entry.busB = {16'd0, imm16};          end
         default:    entry.illegalOp = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode at acceptance and buffer ALU operations in a 2-entry FIFO
module alu_issue
   import alu_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        InValid,
   output logic        InReady,
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Funct,
   input  logic [4:0]  Shamt,
   input  logic [15:0] Imm16,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   input  logic        Flush,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] BusA,
   output logic [31:0] BusB,
   output logic [3:0]  ALUCtrl,
   output logic        IllegalOp
);

   issueEntry_t decoded;
   issueEntry_t fifoMem [2];
   logic [1:0]  count;
   logic        wrPtr;
   logic        rdPtr;
   logic        pushEn;
   logic        popEn;

   alu_decode uDecode (
      .opcode (Opcode),
      .funct  (Funct),
      .shamt  (Shamt),
      .imm16  (Imm16),
      .rsData (RsData),
      .rtData (RtData),
      .entry  (decoded)
   );

   assign InReady  = (count < 2'd2);
   assign OutValid = (count != 2'd0);
   assign pushEn   = InValid && InReady && !Flush;
   assign popEn    = OutValid && OutReady && !Flush;

   // Entries are cleared on reset so the head reads as all-zero while reset is held
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         count      <= 2'd0;
         wrPtr      <= 1'b0;
         rdPtr      <= 1'b0;
         fifoMem[0] <= '0;
         fifoMem[1] <= '0;
      end else if (Flush) begin
         count <= 2'd0;
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
      end else begin
         if (pushEn) begin
            fifoMem[wrPtr] <= decoded;
            wrPtr          <= wrPtr + 1'b1;
         end
         if (popEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushEn, popEn})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign BusA      = fifoMem[rdPtr].busA;
   assign BusB      = fifoMem[rdPtr].busB;
   assign ALUCtrl   = fifoMem[rdPtr].aluCtrl;
   assign IllegalOp = fifoMem[rdPtr].illegalOp;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized scoreboard bench for alu_issue
module tb_alu_issue;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic        ill;
   } expEntry_t;

   logic        CLK = 1'b0;
   logic        Reset_L = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [5:0]  Opcode = '0;
   logic [5:0]  Funct = '0;
   logic [4:0]  Shamt = '0;
   logic [15:0] Imm16 = '0;
   logic [31:0] RsData = '0;
   logic [31:0] RtData = '0;
   logic        Flush = 1'b0;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic [3:0]  ALUCtrl;
   logic        IllegalOp;

   int checks = 0;
   int errors = 0;

   expEntry_t modelQ[$];
   expEntry_t pendEntry;
   logic      pendPush = 1'b0;
   logic      pendFlush = 1'b0;
   logic      monOn = 1'b0;

   int rFn[10]   = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
   int rCtl[10]  = '{2, 8, 6, 9, 0, 1, 10, 12, 7, 11};
   int sFn[3]    = '{'h00, 'h02, 'h03};
   int sCtl[3]   = '{3, 4, 13};
   int iOp[8]    = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};
   int iCtl[8]   = '{2, 8, 7, 11, 0, 1, 10, 14};

   alu_issue dut (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .InValid   (InValid),
      .InReady   (InReady),
      .Opcode    (Opcode),
      .Funct     (Funct),
      .Shamt     (Shamt),
      .Imm16     (Imm16),
      .RsData    (RsData),
      .RtData    (RtData),
      .Flush     (Flush),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .BusA      (BusA),
      .BusB      (BusB),
      .ALUCtrl   (ALUCtrl),
      .IllegalOp (IllegalOp)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected tuple from the instruction-set rules, via lookup tables
   function automatic expEntry_t refDecode(input int op, input int fn, input int sh,
                                           input logic [15:0] im, input logic [31:0] rs,
                                           input logic [31:0] rt);
      expEntry_t e;
      logic [31:0] sext;
      logic [31:0] zext;
      e = '{a: 32'd0, b: 32'd0, c: 4'd2, ill: 1'b1};
      zext = 32'(im);
      sext = (im >= 16'h8000) ? zext + 32'hFFFF_0000 : zext;
      if (op == 0) begin
         for (int i = 0; i < 10; i++)
            if (fn == rFn[i]) e = '{a: rs, b: rt, c: 4'(rCtl[i]), ill: 1'b0};
         for (int i = 0; i < 3; i++)
            if (fn == sFn[i]) e = '{a: rt, b: 32'(sh), c: 4'(sCtl[i]), ill: 1'b0};
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (op == iOp[i]) begin
               e.c = 4'(iCtl[i]);
               e.ill = 1'b0;
               e.a = (op == 'h0F) ? 32'd0 : rs;
               e.b = (op <= 'h0B) ? sext : zext;
            end
         end
      end
      return e;
   endfunction

   task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [15:0] im, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy, input logic fl);
      @(posedge CLK);
      #1;
      if (pendFlush) modelQ.delete();
      else if (pendPush) modelQ.push_back(pendEntry);
      InValid  = v;
      Opcode   = op;
      Funct    = fn;
      Shamt    = sh;
      Imm16    = im;
      RsData   = rs;
      RtData   = rt;
      OutReady = ordy;
      Flush    = fl;
      pendFlush = fl;
      pendPush  = v && !fl && (modelQ.size() < 2);
      pendEntry = refDecode(int'(op), int'(fn), int'(sh), im, rs, rt);
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 32'h0, 32'h0, ordy, 1'b0);
   endtask

   always @(negedge CLK) begin
      if (monOn && Reset_L) begin
         check("InReady", 32'(InReady), 32'(modelQ.size() < 2));
         check("OutValid", 32'(OutValid), 32'(modelQ.size() > 0));
         if (modelQ.size() > 0) begin
            check("BusA", BusA, modelQ[0].a);
            check("BusB", BusB, modelQ[0].b);
            check("ALUCtrl", 32'(ALUCtrl), 32'(modelQ[0].c));
            check("IllegalOp", 32'(IllegalOp), 32'(modelQ[0].ill));
            if (OutReady && !Flush) void'(modelQ.pop_front());
         end
      end
   end

   initial begin
      #12;
      check("rst OutValid", 32'(OutValid), 32'd0);
      check("rst BusA", BusA, 32'd0);
      check("rst ALUCtrl", 32'(ALUCtrl), 32'd0);
      check("rst InReady", 32'(InReady), 32'd1);
      @(negedge CLK);
      Reset_L = 1'b1;
      @(posedge CLK);
      monOn = 1'b1;

      // addi with negative immediate
      drive(1'b1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd9, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge CLK);
      check("addi OutValid", 32'(OutValid), 32'd1);
      check("addi BusA", BusA, 32'd5);
      check("addi BusB", BusB, 32'hFFFF_FFFF);
      check("addi ALUCtrl", 32'(ALUCtrl), 32'd2);
      idle(1'b1);

      // sll
      drive(1'b1, 6'h00, 6'h00, 5'd2, 16'h0000, 32'h1, 32'h1234_5678, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge CLK);
      check("sll BusA", BusA, 32'h1234_5678);
      check("sll BusB", BusB, 32'd2);
      check("sll ALUCtrl", 32'(ALUCtrl), 32'd3);
      idle(1'b1);

      // lui then an undecodable opcode
      drive(1'b1, 6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge CLK);
      check("lui BusA", BusA, 32'd0);
      check("lui BusB", BusB, 32'h0000_1234);
      check("lui ALUCtrl", 32'(ALUCtrl), 32'd14);
      idle(1'b1);
      drive(1'b1, 6'h3F, 6'h20, 5'd7, 16'hABCD, 32'h11, 32'h22, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge CLK);
      check("ill IllegalOp", 32'(IllegalOp), 32'd1);
      check("ill ALUCtrl", 32'(ALUCtrl), 32'd2);
      check("ill BusA", BusA, 32'd0);
      check("ill BusB", BusB, 32'd0);
      idle(1'b1);

      // backpressure: third instruction must be refused
      drive(1'b1, 6'h00, 6'h21, 5'd0, 16'h0, 32'hA1, 32'hB1, 1'b0, 1'b0);
      drive(1'b1, 6'h00, 6'h22, 5'd0, 16'h0, 32'hA2, 32'hB2, 1'b0, 1'b0);
      drive(1'b1, 6'h00, 6'h26, 5'd0, 16'h0, 32'hA3, 32'hB3, 1'b0, 1'b0);
      @(negedge CLK);
      check("full InReady", 32'(InReady), 32'd0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      @(negedge CLK);
      check("drained OutValid", 32'(OutValid), 32'd0);

      // flush while full with an incoming instruction
      drive(1'b1, 6'h0C, 6'h00, 5'd0, 16'h00FF, 32'h1, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 6'h0D, 6'h00, 5'd0, 16'h0F0F, 32'h2, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 6'h0E, 6'h00, 5'd0, 16'h3333, 32'h3, 32'h0, 1'b1, 1'b1);
      idle(1'b0);
      @(negedge CLK);
      check("flush OutValid", 32'(OutValid), 32'd0);
      check("flush InReady", 32'(InReady), 32'd1);

      // asynchronous reset with one entry buffered
      drive(1'b1, 6'h08, 6'h00, 5'd0, 16'h0007, 32'd5, 32'd0, 1'b0, 1'b0);
      idle(1'b0);
      #2;
      monOn = 1'b0;
      Reset_L = 1'b0;
      modelQ.delete();
      pendPush = 1'b0;
      pendFlush = 1'b0;
      #1;
      check("arst OutValid", 32'(OutValid), 32'd0);
      check("arst BusA", BusA, 32'd0);
      check("arst BusB", BusB, 32'd0);
      check("arst ALUCtrl", 32'(ALUCtrl), 32'd0);
      check("arst IllegalOp", 32'(IllegalOp), 32'd0);
      @(negedge CLK);
      Reset_L = 1'b1;
      @(posedge CLK);
      monOn = 1'b1;
      @(negedge CLK);
      check("arst InReady", 32'(InReady), 32'd1);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         logic [5:0]  op;
         logic [5:0]  fn;
         logic [15:0] im;
         logic [31:0] rs;
         logic [31:0] rt;
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
              (($urandom_range(0, 1) == 0) ? 6'h00 : 6'(iOp[$urandom_range(0, 7)]));
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
              (($urandom_range(0, 3) == 0) ? 6'(sFn[$urandom_range(0, 2)]) :
                                             6'(rFn[$urandom_range(0, 9)]));
         im = 16'($urandom);
         rs = $urandom;
         rt = $urandom;
         drive(1'($urandom_range(0, 3) != 0), op, fn, 5'($urandom), im, rs, rt,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
